vpu_control: RTL and testbench

VPU_CONTROL -- requirements
Module: vpu_control

---
 rtl/vpu_control.sv | 207 ++++++++++++++++++++
 tb/tb_vpu_control.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vpu_control.sv
// -----------------------------------------------------------------------------
// vpu_control
//   Sequencer for VPU-class instructions. While the CPU holds a vector
//   instruction in decode (VPU_start high), this block stalls the CPU
//   (VPU_rdy low). It then walks elem_idx through VLEN elements, either as
//   register-to-register ALU work or as load/store memory transactions, and
//   finally retires the instruction through a one-cycle DONE state.
//
// Ports
//   clk        : single clock, all state updates on posedge
//   rst        : synchronous, active-high reset
//   VPU_start  : CPU request, held while the instruction stalls in decode
//   opcode     : 5-bit instruction opcode, stable while VPU_start is high
//   x_bit      : extra opcode bit, stable with opcode
//   mem_ack    : vector memory completion for the current element
//   VPU_rdy    : low stalls the CPU (combinational)
//   elem_idx   : current element index
//   valu_op    : latched opcode[2:0]
//   valu_x     : latched x_bit
//   vreg_re/we : vector register file read / write strobes
//   vmem_re/we : vector memory request strobes (one-cycle pulses)
//   illegal    : one-cycle pulse (in DONE) for an unsupported opcode
//   mem_err    : sticky memory timeout flag, cleared on the next accept
// -----------------------------------------------------------------------------
module vpu_control #(
  parameter int VLEN        = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       VPU_start,
  input  logic [4:0] opcode,
  input  logic       x_bit,
  input  logic       mem_ack,
  output logic       VPU_rdy,
  output logic [3:0] elem_idx,
  output logic [2:0] valu_op,
  output logic       valu_x,
  output logic       vreg_re,
  output logic       vreg_we,
  output logic       vmem_re,
  output logic       vmem_we,
  output logic       illegal,
  output logic       mem_err
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ALU      = 3'd1;
  localparam logic [2:0] S_MEM_REQ  = 3'd2;
  localparam logic [2:0] S_MEM_WAIT = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  localparam logic [3:0] LAST_IDX = 4'(VLEN - 1);
  // The wait counter is compared before it increments, so the final wait
  // cycle is the one where the count is one below the timeout.
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  localparam logic [4:0] OP_VLD = 5'b11000;
  localparam logic [4:0] OP_VST = 5'b11001;

  logic [2:0] state_q, state_d;
  logic [3:0] elem_q,  elem_d;
  logic [2:0] op_q,    op_d;
  logic       x_q,     x_d;
  logic       store_q, store_d;
  logic       ill_q,   ill_d;
  logic       err_q,   err_d;
  logic [7:0] wcnt_q,  wcnt_d;

  // Next-state and datapath register update logic
  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    op_d    = op_q;
    x_d     = x_q;
    store_d = store_q;
    ill_d   = ill_q;
    err_d   = err_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_IDLE: begin
        if (VPU_start) begin
          op_d    = opcode[2:0];
          x_d     = x_bit;
          elem_d  = 4'd0;
          err_d   = 1'b0;
          wcnt_d  = 8'd0;
          store_d = (opcode == OP_VST);
          ill_d   = 1'b0;
          if (opcode[4:3] == 2'b10) begin
            state_d = S_ALU;
          end else if ((opcode == OP_VLD) || (opcode == OP_VST)) begin
            state_d = S_MEM_REQ;
          end else begin
            ill_d   = 1'b1;
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ALU: begin
        // elem_idx stops on the last element so it holds VLEN-1 through DONE
        if (elem_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          elem_d = elem_q + 4'd1;
        end
      end
      S_MEM_REQ: begin
        wcnt_d  = 8'd0;
        state_d = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        // An ack in the same cycle as the timeout takes priority
        if (mem_ack) begin
          if (elem_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            elem_d  = elem_q + 4'd1;
            state_d = S_MEM_REQ;
          end
        end else if (wcnt_q == TMO_LAST) begin
          wcnt_d  = wcnt_q + 8'd1;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      elem_q  <= 4'd0;
      op_q    <= 3'd0;
      x_q     <= 1'b0;
      store_q <= 1'b0;
      ill_q   <= 1'b0;
      err_q   <= 1'b0;
      wcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      op_q    <= op_d;
      x_q     <= x_d;
      store_q <= store_d;
      ill_q   <= ill_d;
      err_q   <= err_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Output decode; reset overrides the state so a mid-instruction reset
  // silences every strobe in the cycle it is asserted.
  always_comb begin
    VPU_rdy = 1'b0;
    vreg_re = 1'b0;
    vreg_we = 1'b0;
    vmem_re = 1'b0;
    vmem_we = 1'b0;
    illegal = 1'b0;
    if (rst) begin
      VPU_rdy = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          VPU_rdy = ~VPU_start;
        end
        S_ALU: begin
          vreg_re = 1'b1;
          vreg_we = 1'b1;
        end
        S_MEM_REQ: begin
          vmem_re = ~store_q;
          vmem_we = store_q;
          vreg_re = store_q;
        end
        S_MEM_WAIT: begin
          vreg_we = mem_ack & ~store_q;
        end
        S_DONE: begin
          VPU_rdy = 1'b1;
          illegal = ill_q;
        end
        default: begin
          VPU_rdy = 1'b0;
        end
      endcase
    end
  end

  assign elem_idx = elem_q;
  assign valu_op  = op_q;
  assign valu_x   = x_q;
  assign mem_err  = err_q;

endmodule

// File: tb/tb_vpu_control.sv
module tb_vpu_control;
  localparam int VLEN = 16;
  localparam int TMO  = 4;

  logic       clk;
  logic       rst;
  logic       VPU_start;
  logic [4:0] opcode;
  logic       x_bit;
  logic       mem_ack;
  logic       VPU_rdy;
  logic [3:0] elem_idx;
  logic [2:0] valu_op;
  logic       valu_x;
  logic       vreg_re, vreg_we, vmem_re, vmem_we, illegal, mem_err;

  int n_tests = 0;
  int n_fail  = 0;
  int lat_q[VLEN];        // ack latency per element (waits after request)
  int exp_elem_after = 0; // elem_idx expected while idle, -1 if not checked

  vpu_control #(.VLEN(VLEN), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .VPU_start(VPU_start), .opcode(opcode),
    .x_bit(x_bit), .mem_ack(mem_ack), .VPU_rdy(VPU_rdy), .elem_idx(elem_idx),
    .valu_op(valu_op), .valu_x(valu_x), .vreg_re(vreg_re), .vreg_we(vreg_we),
    .vmem_re(vmem_re), .vmem_we(vmem_we), .illegal(illegal), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one instruction from accept through its DONE cycle and checks it
  // against counts and timing derived from the instruction's rules.
  task automatic run_instr(input logic [4:0] op, input logic xb);
    bit is_alu, is_ld, is_st, is_ill, tmo, done, outst;
    int n_ok, exp_low, low_cyc, re_cnt, we_cnt, vm_cnt, wctr, cur;
    int idx_bad, ill_bad, we_noack, err_bad, strobe_done;
    logic done_ill, done_err;
    logic [3:0] done_elem;
    logic [2:0] done_op;
    logic done_x;
    is_alu = (op[4:3] == 2'b10);
    is_ld  = (op == 5'b11000);
    is_st  = (op == 5'b11001);
    is_ill = !(is_alu || is_ld || is_st);
    n_ok = 0; tmo = 1'b0;
    if (is_alu) exp_low = VLEN + 1;
    else if (is_ld || is_st) begin
      while (n_ok < VLEN && lat_q[n_ok] <= TMO) n_ok++;
      tmo = (n_ok < VLEN);
      exp_low = 1;
      for (int i = 0; i < n_ok; i++) exp_low += 1 + lat_q[i];
      if (tmo) exp_low += 1 + TMO;
    end else exp_low = 1;
    low_cyc = 0; re_cnt = 0; we_cnt = 0; vm_cnt = 0; wctr = 0; cur = 0;
    idx_bad = 0; ill_bad = 0; we_noack = 0; err_bad = 0; strobe_done = 0;
    done = 1'b0; outst = 1'b0;
    done_ill = 1'b0; done_err = 1'b0; done_elem = 4'd0; done_op = 3'd0; done_x = 1'b0;
    VPU_start = 1'b1; opcode = op; x_bit = xb;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      if (outst) begin
        wctr++;
        mem_ack = (wctr == lat_q[cur]);
      end else mem_ack = 1'($urandom_range(0, 1));
      #1;
      if (VPU_rdy) begin
        done = 1'b1;
        if (vreg_re || vreg_we || vmem_re || vmem_we) strobe_done++;
        done_ill = illegal; done_err = mem_err; done_elem = elem_idx;
        done_op = valu_op; done_x = valu_x;
      end else begin
        low_cyc++;
        if (illegal) ill_bad++;
        if (cyc == 1 && mem_err) err_bad++;
        if (vreg_re) re_cnt++;
        if (vreg_we) begin
          we_cnt++;
          if (!is_alu && !(outst && mem_ack)) we_noack++;
        end
        if (is_alu && vreg_re && elem_idx !== 4'(re_cnt - 1)) idx_bad++;
        if (outst && mem_ack) begin outst = 1'b0; cur++; end
        if (outst && wctr == TMO) outst = 1'b0;
        if (vmem_re || vmem_we) begin
          if (elem_idx !== 4'(vm_cnt)) idx_bad++;
          if (vmem_re && !is_ld) idx_bad++;
          if (vmem_we && !is_st) idx_bad++;
          vm_cnt++; outst = 1'b1; wctr = 0;
        end
      end
      @(posedge clk); #1;
    end
    n_tests++;
    if (!done) begin n_fail++; $display("FAIL done_timeout op=%b: DONE never reached", op); end
    n_tests++;
    if (low_cyc != exp_low) begin n_fail++; $display("FAIL stall_cycles op=%b: got %0d expected %0d", op, low_cyc, exp_low); end
    n_tests++;
    if (re_cnt != (is_alu ? VLEN : (is_st ? n_ok + int'(tmo) : 0))) begin
      n_fail++; $display("FAIL vreg_re_count op=%b: got %0d", op, re_cnt); end
    n_tests++;
    if (we_cnt != (is_alu ? VLEN : (is_ld ? n_ok : 0))) begin
      n_fail++; $display("FAIL vreg_we_count op=%b: got %0d", op, we_cnt); end
    n_tests++;
    if (vm_cnt != ((is_ld || is_st) ? n_ok + int'(tmo) : 0)) begin
      n_fail++; $display("FAIL vmem_count op=%b: got %0d expected %0d", op, vm_cnt, n_ok + int'(tmo)); end
    n_tests++;
    if (idx_bad + ill_bad + we_noack + err_bad + strobe_done != 0) begin
      n_fail++; $display("FAIL sequence op=%b: idx_bad=%0d ill_bad=%0d we_noack=%0d err_bad=%0d strobe_done=%0d expected all 0",
                         op, idx_bad, ill_bad, we_noack, err_bad, strobe_done); end
    n_tests++;
    if (done_ill !== is_ill) begin n_fail++; $display("FAIL illegal_done op=%b: got %b expected %b", op, done_ill, is_ill); end
    n_tests++;
    if (done_err !== tmo) begin n_fail++; $display("FAIL mem_err op=%b: got %b expected %b", op, done_err, tmo); end
    n_tests++;
    if (done_op !== op[2:0] || done_x !== xb) begin
      n_fail++; $display("FAIL valu_latch op=%b: got op=%b x=%b expected op=%b x=%b", op, done_op, done_x, op[2:0], xb); end
    exp_elem_after = -1;
    if (tmo) exp_elem_after = n_ok;
    if (is_ill) exp_elem_after = 0;
    if (exp_elem_after >= 0) begin
      n_tests++;
      if (done_elem !== 4'(exp_elem_after)) begin
        n_fail++; $display("FAIL elem_done op=%b: got %0d expected %0d", op, done_elem, exp_elem_after); end
    end
  endtask

  // Idle cycles with VPU_start low: ready, quiet, elem_idx held.
  task automatic idle_cycles(input int n);
    VPU_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      mem_ack = 1'($urandom_range(0, 1));
      #1;
      n_tests++;
      if (VPU_rdy !== 1'b1 || {vreg_re, vreg_we, vmem_re, vmem_we, illegal} !== 5'b0) begin
        n_fail++; $display("FAIL idle_quiet: rdy=%b strobes=%b expected rdy=1 strobes=0", VPU_rdy,
                           {vreg_re, vreg_we, vmem_re, vmem_we, illegal}); end
      if (exp_elem_after >= 0) begin
        n_tests++;
        if (elem_idx !== 4'(exp_elem_after)) begin
          n_fail++; $display("FAIL idle_elem: got %0d expected %0d", elem_idx, exp_elem_after); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic fill_lat(input int fixed);
    for (int i = 0; i < VLEN; i++)
      lat_q[i] = (fixed > 0) ? fixed :
                 (($urandom_range(0, 19) == 0) ? int'($urandom_range(TMO + 1, TMO + 3)) : int'($urandom_range(1, TMO)));
  endtask

  task automatic test_reset();
    rst = 1'b1; VPU_start = 1'b1; opcode = 5'b10000;
    for (int i = 0; i < 3; i++) begin
      mem_ack = 1'($urandom_range(0, 1));
      #1;
      n_tests++;
      if (VPU_rdy !== 1'b1 || {vreg_re, vreg_we, vmem_re, vmem_we, illegal} !== 5'b0) begin
        n_fail++; $display("FAIL reset_hold: rdy=%b strobes=%b expected rdy=1 strobes=0", VPU_rdy,
                           {vreg_re, vreg_we, vmem_re, vmem_we, illegal}); end
      @(posedge clk); #1;
    end
    rst = 1'b0; VPU_start = 1'b0;
    #1;
    n_tests++;
    if (VPU_rdy !== 1'b1 || elem_idx !== 4'd0 || valu_op !== 3'd0 || valu_x !== 1'b0 || mem_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: rdy=%b elem=%0d op=%b x=%b err=%b expected 1 0 000 0 0",
                         VPU_rdy, elem_idx, valu_op, valu_x, mem_err); end
    @(posedge clk); #1;
    exp_elem_after = 0;
  endtask

  task automatic test_alu();
    run_instr(5'b10011, 1'b1);
    idle_cycles(2);
    for (int i = 0; i < 3; i++) begin
      run_instr(5'b10000 | 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      idle_cycles(1);
    end
  endtask

  task automatic test_vld();
    fill_lat(2);
    run_instr(5'b11000, 1'b0);
    idle_cycles(2);
    fill_lat(TMO);            // ack in the final allowed wait cycle
    run_instr(5'b11000, 1'b1);
    idle_cycles(1);
  endtask

  task automatic test_vst_timeout();
    fill_lat(99);
    run_instr(5'b11001, 1'b0);
    idle_cycles(2);
    run_instr(5'b10101, 1'b0); // accept must clear mem_err
    idle_cycles(1);
    fill_lat(1);
    lat_q[6] = TMO + 1;        // timeout on a later element
    run_instr(5'b11001, 1'b1);
    idle_cycles(1);
    fill_lat(3);
    run_instr(5'b11001, 1'b0);
    idle_cycles(1);
  endtask

  task automatic test_illegal();
    logic [4:0] op;
    run_instr(5'b11010, 1'b0);
    idle_cycles(1);
    for (int i = 0; i < 3; i++) begin
      op = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 15)) : 5'($urandom_range(26, 31));
      run_instr(op, 1'($urandom_range(0, 1)));
      idle_cycles(1);
    end
  endtask

  task automatic test_back_to_back();
    run_instr(5'b10001, 1'b0);
    run_instr(5'b10110, 1'b1);
    idle_cycles(2);
  endtask

  task automatic test_random();
    int k;
    for (int i = 0; i < 20; i++) begin
      k = $urandom_range(0, 9);
      fill_lat(0);
      if (k < 4)      run_instr(5'b10000 | 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      else if (k < 6) run_instr(5'b11000, 1'($urandom_range(0, 1)));
      else if (k < 8) run_instr(5'b11001, 1'($urandom_range(0, 1)));
      else            run_instr(5'($urandom_range(26, 31)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
    end
    idle_cycles(1);
  endtask

  task automatic test_reset_midop();
    bit hit;
    hit = 1'b0;
    VPU_start = 1'b1; opcode = 5'b10010; x_bit = 1'b0; mem_ack = 1'b0;
    for (int cyc = 0; cyc < 40 && !hit; cyc++) begin
      #1;
      if (vreg_re && elem_idx == 4'd5) begin
        hit = 1'b1;
        rst = 1'b1;
        #1;
        n_tests++;
        if (VPU_rdy !== 1'b1 || {vreg_re, vreg_we, vmem_re, vmem_we, illegal} !== 5'b0) begin
          n_fail++; $display("FAIL reset_mid_force: rdy=%b strobes=%b expected 1 and 0", VPU_rdy,
                             {vreg_re, vreg_we, vmem_re, vmem_we, illegal}); end
      end
      @(posedge clk); #1;
    end
    n_tests++;
    if (!hit) begin n_fail++; $display("FAIL reset_mid_reach: element 5 never seen"); end
    rst = 1'b0; VPU_start = 1'b0;
    #1;
    n_tests++;
    if (VPU_rdy !== 1'b1 || elem_idx !== 4'd0 || {vreg_re, vreg_we, illegal} !== 3'b0) begin
      n_fail++; $display("FAIL reset_mid_idle: rdy=%b elem=%0d strobes=%b expected 1 0 000", VPU_rdy, elem_idx,
                         {vreg_re, vreg_we, illegal}); end
    @(posedge clk); #1;
    exp_elem_after = 0;
    idle_cycles(3);
  endtask

  initial begin
    rst = 1'b1; VPU_start = 1'b0; opcode = 5'd0; x_bit = 1'b0; mem_ack = 1'b0;
    for (int i = 0; i < VLEN; i++) lat_q[i] = 1;
    @(posedge clk); #1;
    test_reset();
    test_alu();
    test_vld();
    test_vst_timeout();
    test_illegal();
    test_back_to_back();
    test_random();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
